glyph_scanner: RTL and testbench
================================

Name: glyph_scanner

Overview:
- Initiator side of the 1-bit glyph ROM interface. On a start pulse, walks ROM addresses 0..DEPTH-1 and captures each returned pixel.
- ROM read latency is one clock: address is sampled on the clock edge and q is valid the following cycle.
- Streams pixels, with x/y coordinates, to the display compositor over a valid/ready handshake, and tolerates arbitrary backpressure.
- Sits between the per-digit glyph ROMs (one is selected by an external mux) and the display pixel writer.

Parameters:
- ADDR_W, 7: ROM address width.
- DEPTH, 128: number of glyph pixels. Must equal 2**ADDR_W.
- COLS, 8: pixels per glyph row. Power of two; DEPTH/COLS rows.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  synchronous active-low reset.
- start  in  1  single-cycle request to scan one glyph. Ignored while busy.
- busy  out  1  high from the cycle after an accepted start until done.
- rom_address  out  ADDR_W  registered address to the glyph ROM.
- rom_q  in  1  ROM data, valid one cycle after the address was presented.
- pix_valid  out  1  output pixel available.
- pix_ready  in  1  consumer accepts the pixel when valid&&ready.
- pix_data  out  1  pixel value.
- pix_x  out  $clog2(COLS)  column, equal to idx mod COLS.
- pix_y  out  ADDR_W-$clog2(COLS)  row, equal to idx / COLS.
- pix_last  out  1  high with pixel DEPTH-1.
- done  out  1  one-cycle pulse in the cycle after the last pixel is accepted.

Behaviour:
- Reset (reset_n low at a clock edge) clears everything:
  - rom_address=0, busy=0, pix_valid=0, pix_data=0, pix_x=0, pix_y=0, pix_last=0, done=0.
  - The FSM goes to IDLE and the buffer is emptied.
  - A reset in the middle of a scan aborts it. No done pulse is produced, and no stale pixels appear after reset.
- FSM states:
  - IDLE: start=1 goes to RUN. issue_idx is cleared to 0 and busy=1 from the next cycle.
  - RUN: issues ROM reads. After address DEPTH-1 has been issued, goes to DRAIN.
  - DRAIN: waits until the last pixel is accepted, then goes to IDLE, pulses done, and clears busy in the same cycle.
- Issue rule:
  - An address is issued only when occupancy + in_flight < 2. The buffer holds 2 entries; in_flight is 0 or 1.
  - Issuing drives rom_address=issue_idx and then increments issue_idx.
  - In the cycle after an issue, rom_q is written into the buffer together with its index.
  - This rule guarantees the buffer never overflows and no ROM data is lost.
- Throughput and latency:
  - With pix_ready held at 1, one pixel is delivered per cycle.
  - The first pix_valid rises 3 cycles after the start cycle: issue register, ROM register, buffer register.
  - A full glyph takes DEPTH+3 cycles from start to done.
- Output ordering: pixels appear in strictly ascending index order.
- Handshake:
  - pix_data, pix_x, pix_y and pix_last are held stable while pix_valid=1 and pix_ready=0.
  - pix_valid is never withdrawn before the transfer completes.
- Wrap-around: issue_idx is ADDR_W+1 bits wide. The terminal condition is issue_idx==DEPTH, so there is no aliasing back to address 0.
- Simultaneous events:
  - start in the same cycle as done is ignored. The consumer must re-issue start once busy=0.
  - Accept and buffer-write in the same cycle are allowed; occupancy stays unchanged.
- rom_address holds its last value while idle.

Optional Feature:
- Macro: GLYPH_SCANNER_INVERT_EN.
- Defined:
  - Adds input port invert (1 bit).
  - invert is sampled when start is accepted and held for the whole scan.
  - pix_data = rom_q XOR latched invert. This gives highlighted (reverse-video) digits.
- Undefined: the port is absent and pix_data = rom_q exactly.

Decomposition:
- Shared package glyph_pkg holds:
  - GLYPH_ADDR_W=7, GLYPH_DEPTH=128, GLYPH_COLS=8.
  - The FSM state enum (IDLE, RUN, DRAIN).
- Sub-module glyph_skid_buf: a 2-entry FIFO of {data, idx}, exposing count, wr_en, valid/ready.
- The top level holds the FSM, the issue counter and the in_flight flag.

Test Plan:
- ROM model loaded with the digit-5 bitmap; start, pix_ready=1:
  - Exactly 128 pixels in order.
  - Addresses 26..30 give 1 and address 31 gives 0.
  - Pixel 41 has x=1, y=5, data=1.
  - pix_last only on index 127.
  - done at start+131.
- Random pix_ready at 30% duty:
  - Stream identical to the ideal stream.
  - Data, x and y stable while stalled.
  - No index skipped or duplicated.
- pix_ready held at 0 for 50 cycles after start:
  - Exactly 2 ROM reads issued, rom_address stalled at 2.
  - On release, all 128 pixels are delivered intact.
- reset_n pulsed low at pixel 60 under backpressure:
  - All outputs return to 0 next cycle, no done pulse.
  - A new start yields a clean scan from index 0.
- start pulsed while busy, and again in the done cycle:
  - Both ignored, busy profile unchanged.
  - A start 1 cycle later begins a new scan.
- GLYPH_SCANNER_INVERT_EN defined, invert=1 at start then toggled mid-scan:
  - All 128 pixels are the inverse of the bitmap.
  - The mid-scan toggle has no effect.

Source files
------------

// File: rtl/glyph_pkg.sv
// Shared constants and FSM state type for the glyph scanner slice.
// Optional feature macro: GLYPH_SCANNER_INVERT_EN (reverse-video output).
package glyph_pkg;

  localparam int GLYPH_ADDR_W = 7;
  localparam int GLYPH_DEPTH  = 128;
  localparam int GLYPH_COLS   = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

endpackage

// File: rtl/glyph_scanner_if.sv
// Pixel stream from the glyph scanner to the display compositor.
// The master drives valid/data/x/y/last, the slave answers with ready.
interface glyph_scanner_if #(
  parameter int ADDR_W = glyph_pkg::GLYPH_ADDR_W,
  parameter int COLS   = glyph_pkg::GLYPH_COLS
);

  localparam int XW = $clog2(COLS);
  localparam int YW = ADDR_W - XW;

  logic          valid;
  logic          ready;
  logic          data;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          last;

  modport master (output valid, data, x, y, last, input ready);
  modport slave  (input valid, data, x, y, last, output ready);

endinterface

// File: rtl/glyph_skid_buf.sv
// Two-entry FIFO holding {pixel, index} between the ROM read and the
// pixel stream. The scanner never writes it while full without a pop.
module glyph_skid_buf #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  output logic         valid,
  input  logic         ready,
  output logic [W-1:0] rd_data,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic         pop;

  assign valid   = (count != 2'd0);
  assign pop     = valid & ready;
  assign rd_data = mem[rd_ptr];

  // Storage, pointers and occupancy; a push and a pop may share a cycle.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      // NOTE: the entries are cleared too, because the head entry is driven
      // straight onto the pixel outputs and those must read zero after reset.
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(wr_en) - 2'(pop);
    end
  end

endmodule

// File: rtl/glyph_scanner.sv
// Glyph scanner: reads a 1-bit glyph ROM (one-cycle read latency) address
// by address and streams every pixel with its x/y position.
// Optional feature macro: GLYPH_SCANNER_INVERT_EN adds an 'invert' input
// that is latched at start and XORed into every pixel of the scan.
module glyph_scanner
  import glyph_pkg::*;
#(
  parameter int ADDR_W = GLYPH_ADDR_W,
  parameter int DEPTH  = GLYPH_DEPTH,
  parameter int COLS   = GLYPH_COLS
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
`ifdef GLYPH_SCANNER_INVERT_EN
  input  logic              invert,
`endif
  output logic              busy,
  output logic [ADDR_W-1:0] rom_address,
  input  logic              rom_q,
  output logic              done,
  glyph_scanner_if.master   pix
);

  localparam int XW = $clog2(COLS);
  localparam int EW = ADDR_W + 1;
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W:0]   issue_idx;
  logic              in_flight;
  logic [ADDR_W-1:0] flight_idx;
  logic              pix_bit;
  logic [1:0]        count;
  logic [2:0]        claimed;
  logic              accept;
  logic              start_ok;
  logic              issue;
  logic              last_issue;
  logic              last_accept;
  logic              buf_valid;
  logic [EW-1:0]     head;
  logic [ADDR_W-1:0] head_idx;

  assign accept      = pix.valid & pix.ready;
  assign start_ok    = (state == IDLE) && start && !done;
  // Buffer slots already spoken for: entries left after this cycle's pop
  // plus the read whose data lands next cycle. Counting the pop keeps one
  // pixel per cycle flowing when the consumer is always ready.
  assign claimed     = 3'(count) + 3'(in_flight) - 3'(accept);
  assign issue       = (state == RUN) && (claimed < 3'd2);
  assign last_issue  = issue && (issue_idx == LAST_IDX);
  assign last_accept = accept && pix.last;
  assign busy        = (state != IDLE);

`ifdef GLYPH_SCANNER_INVERT_EN
  logic inv_q;

  // Polarity chosen at start and held for the whole scan.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      inv_q <= 1'b0;
    end else if (start_ok) begin
      inv_q <= invert;
    end
  end

  assign pix_bit = rom_q ^ inv_q;
`else
  assign pix_bit = rom_q;
`endif

  // State register.
  always_ff @(posedge clock) begin
    // NOTE: clocked state uses non-blocking assignment so every register
    // samples the pre-edge values regardless of statement order.
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: IDLE -> RUN on start, RUN -> DRAIN after the last
  // read is issued, DRAIN -> IDLE once the last pixel is taken.
  always_comb begin
    // NOTE: default first, so no path leaves state_next unassigned (no latch).
    state_next = state;
    unique case (state)
      IDLE:    if (start_ok)    state_next = RUN;
      RUN:     if (last_issue)  state_next = DRAIN;
      DRAIN:   if (last_accept) state_next = IDLE;
      default:                  state_next = IDLE;
    endcase
  end

  // Issue counter, ROM address, in-flight tracking and the done pulse.
  // rom_address always shows the next index to read; an issue is the cycle
  // in which the ROM samples it, so its data is captured the cycle after.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      issue_idx   <= '0;
      rom_address <= '0;
      in_flight   <= 1'b0;
      flight_idx  <= '0;
      done        <= 1'b0;
    end else begin
      done      <= (state == DRAIN) && last_accept;
      in_flight <= issue;
      if (issue) begin
        flight_idx <= issue_idx[ADDR_W-1:0];
      end
      if (start_ok) begin
        issue_idx   <= '0;
        rom_address <= '0;
      end else if (issue) begin
        issue_idx <= issue_idx + 1'b1;
        // Stay on the final address rather than wrapping to 0.
        if (!last_issue) begin
          rom_address <= issue_idx[ADDR_W-1:0] + 1'b1;
        end
      end
    end
  end

  glyph_skid_buf #(
    .W (EW)
  ) u_buf (
    .clock   (clock),
    .reset_n (reset_n),
    .wr_en   (in_flight),
    .wr_data ({pix_bit, flight_idx}),
    .valid   (buf_valid),
    .ready   (pix.ready),
    .rd_data (head),
    .count   (count)
  );

  assign head_idx  = head[ADDR_W-1:0];
  assign pix.valid = buf_valid;
  assign pix.data  = head[ADDR_W];
  assign pix.x     = head_idx[XW-1:0];
  assign pix.y     = head_idx[ADDR_W-1:XW];
  assign pix.last  = buf_valid && (head_idx == LAST_IDX[ADDR_W-1:0]);

endmodule

// File: tb/tb_glyph_scanner.sv
// Self-checking bench for glyph_scanner: ROM model holding a digit-5
// bitmap, scoreboard of expected {last, y, x, data} words per scan.
// Optional feature macro: GLYPH_SCANNER_INVERT_EN (adds the invert scan).
module tb_glyph_scanner;

  localparam int ADDR_W = 7;
  localparam int DEPTH  = 128;
  localparam int COLS   = 8;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              busy;
  logic [ADDR_W-1:0] rom_address;
  logic              rom_q = 1'b0;
  logic              done;
`ifdef GLYPH_SCANNER_INVERT_EN
  logic              invert = 1'b0;
`endif

  glyph_scanner_if #(.ADDR_W(ADDR_W), .COLS(COLS)) pix_if ();

  glyph_scanner #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .COLS   (COLS)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
`ifdef GLYPH_SCANNER_INVERT_EN
    .invert      (invert),
`endif
    .busy        (busy),
    .rom_address (rom_address),
    .rom_q       (rom_q),
    .done        (done),
    .pix         (pix_if)
  );

  always #5 clock = ~clock;

  // Digit 5, 8 columns x 16 rows; bit 7 of each row is column 0.
  logic [7:0] rows [16] = '{
    8'b00000000, 8'b00000000, 8'b00000000, 8'b00111110,
    8'b01000000, 8'b01000000, 8'b01000000, 8'b01111100,
    8'b00000010, 8'b00000010, 8'b00000010, 8'b00000010,
    8'b01000010, 8'b00111100, 8'b00000000, 8'b00000000
  };

  function automatic logic bitmap(input logic [6:0] idx);
    logic [7:0] r;
    r = rows[idx[6:3]];
    return r[3'd7 - idx[2:0]];
  endfunction

  // Synchronous ROM: address sampled at the edge, data valid next cycle.
  always @(posedge clock) rom_q <= bitmap(rom_address);

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard and monitor state.
  logic [8:0] exp_q [$];
  logic [8:0] obs_word [DEPTH];
  logic [8:0] word;
  int acc_cnt = 0;
  int last_cnt = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int first_valid_cyc = -1;
  int s_cyc = 0;
  bit rdy_rand = 1'b0;

  assign word = {pix_if.last, pix_if.y, pix_if.x, pix_if.data};

  // Sample outputs mid-cycle; a shown pixel must be the scoreboard head,
  // which also proves it is held unchanged while stalled.
  always @(negedge clock) begin
    if (reset_n) begin
      if (pix_if.valid) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        check("queue_nonempty", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("pixel", 32'(word), 32'(exp_q[0]));
        if (pix_if.ready) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          if (acc_cnt < DEPTH) obs_word[acc_cnt] = word;
          acc_cnt++;
          if (pix_if.last) last_cnt++;
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
    if (rdy_rand) pix_if.ready = ($urandom_range(0, 9) < 3);
  endtask

  task automatic push_scan(input bit inv);
    logic [6:0] idx;
    for (int i = 0; i < DEPTH; i++) begin
      idx = 7'(i);
      exp_q.push_back({(i == DEPTH - 1), idx[6:3], idx[2:0], bitmap(idx) ^ inv});
    end
  endtask

  task automatic start_scan(input bit inv);
    push_scan(inv);
    acc_cnt = 0;
    last_cnt = 0;
    first_valid_cyc = -1;
    start = 1'b1;
    s_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      tick();
      n++;
    end
    check("done_seen", 32'(done_cnt != d0), 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rom_address"}, 32'(rom_address), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_valid"}, 32'(pix_if.valid), 0);
    check({tag, "_data"}, 32'(pix_if.data), 0);
    check({tag, "_x"}, 32'(pix_if.x), 0);
    check({tag, "_y"}, 32'(pix_if.y), 0);
    check({tag, "_last"}, 32'(pix_if.last), 0);
    check({tag, "_done"}, 32'(done), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int d0;
    pix_if.ready = 1'b1;

    // Reset state.
    repeat (3) tick();
    check_all_zero("reset");
    reset_n = 1'b1;
    tick();

    // Ideal stream, consumer always ready.
    start_scan(1'b0);
    check("busy_after_start", 32'(busy), 1);
    wait_done(400);
    check("first_valid_latency", 32'(first_valid_cyc - s_cyc), 3);
    check("done_latency", 32'(done_cyc - s_cyc), 131);
    check("ideal_count", 32'(acc_cnt), DEPTH);
    check("ideal_queue_left", 32'(exp_q.size()), 0);
    check("ideal_last_count", 32'(last_cnt), 1);
    for (int a = 26; a <= 30; a++) check("digit_row3_on", 32'(obs_word[a][0]), 1);
    check("digit_addr31_off", 32'(obs_word[31][0]), 0);
    check("pixel41", 32'(obs_word[41]), 32'({1'b0, 4'd5, 3'd1, 1'b1}));
    check("busy_idle", 32'(busy), 0);
    check("rom_address_hold", 32'(rom_address), DEPTH - 1);

    // Random backpressure at ~30% ready.
    rdy_rand = 1'b1;
    start_scan(1'b0);
    wait_done(3000);
    rdy_rand = 1'b0;
    pix_if.ready = 1'b1;
    check("random_count", 32'(acc_cnt), DEPTH);
    check("random_queue_left", 32'(exp_q.size()), 0);
    check("random_last_count", 32'(last_cnt), 1);

    // Consumer stalled for 50 cycles right after start.
    pix_if.ready = 1'b0;
    start_scan(1'b0);
    repeat (50) tick();
    check("stall_rom_address", 32'(rom_address), 2);
    check("stall_busy", 32'(busy), 1);
    check("stall_valid", 32'(pix_if.valid), 1);
    check("stall_accepted", 32'(acc_cnt), 0);
    pix_if.ready = 1'b1;
    wait_done(400);
    check("stall_count", 32'(acc_cnt), DEPTH);
    check("stall_queue_left", 32'(exp_q.size()), 0);

    // Reset in the middle of a scan under backpressure.
    rdy_rand = 1'b1;
    start_scan(1'b0);
    begin
      int n = 0;
      while (acc_cnt < 60 && n < 1000) begin
        tick();
        n++;
      end
    end
    check("reach_pixel60", 32'(acc_cnt >= 60), 1);
    rdy_rand = 1'b0;
    pix_if.ready = 1'b1;
    d0 = done_cnt;
    reset_n = 1'b0;
    tick();
    check_all_zero("midreset");
    exp_q.delete();
    reset_n = 1'b1;
    repeat (10) tick();
    check("midreset_no_done", 32'(done_cnt - d0), 0);
    check("midreset_no_valid", 32'(pix_if.valid), 0);
    start_scan(1'b0);
    wait_done(400);
    check("rescan_count", 32'(acc_cnt), DEPTH);
    check("rescan_first_valid", 32'(first_valid_cyc - s_cyc), 3);
    check("rescan_queue_left", 32'(exp_q.size()), 0);

    // Starts while busy and in the done cycle are ignored.
    start_scan(1'b0);
    s = s_cyc;
    while (cyc < s + 20) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_ignored_start", 32'(busy), 1);
    while (cyc < s + 131) tick();
    check("done_cycle_done", 32'(done), 1);
    check("done_cycle_busy", 32'(busy), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("after_done_start_busy", 32'(busy), 0);
    check("after_done_start_done", 32'(done), 0);
    check("ignore_queue_left", 32'(exp_q.size()), 0);
    start_scan(1'b0);
    check("restart_busy", 32'(busy), 1);
    wait_done(400);
    check("restart_done_latency", 32'(done_cyc - s_cyc), 131);
    check("restart_count", 32'(acc_cnt), DEPTH);

`ifdef GLYPH_SCANNER_INVERT_EN
    // Reverse video, invert toggled mid-scan must not matter.
    invert = 1'b1;
    start_scan(1'b1);
    while (cyc < s_cyc + 60) tick();
    invert = 1'b0;
    wait_done(400);
    check("invert_count", 32'(acc_cnt), DEPTH);
    check("invert_queue_left", 32'(exp_q.size()), 0);
    check("invert_pixel31", 32'(obs_word[31][0]), 1);
`endif

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
